// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the stopwatch display stage.
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
package stopwatch_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [5:0] CLAMP_MAX = 6'd59;
  localparam logic [2:0] SHIFT_CNT = 3'd6;

  function automatic logic [5:0] clamp59(
    input logic [5:0] v
  );
    return (v > CLAMP_MAX) ? CLAMP_MAX : v;
  endfunction

  // One double-dabble step: adjust nibbles >=5, then shift in a bit.
  // Results never exceed 0x59, so the tens nibble fits in 3 bits.
  function automatic logic [7:0] bcd_step(
    input logic [7:0] b,
    input logic       in_bit
  );
    logic [3:0] hi;
    logic [3:0] lo;
    hi = b[7:4];
    lo = b[3:0];
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {3'(hi + ((hi >= 4'd5) ? 4'd3 : 4'd0)), lo, in_bit};
  endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decode.sv
// Combinational BCD to 7-segment lookup, active-high.
// Codes 10-15 show nothing.
module seg7_decode
  import stopwatch_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch display: binary mm:ss to BCD via shift-add-3,
// then multiplexed onto a 4-digit 7-segment display.
module stopwatch_display
  import stopwatch_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [5:0] min_bin,
  input  logic [5:0] sec_bin,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'hF : 4'h0;
  localparam logic       DP_OFF  = COMMON_ANODE;

  conv_state_e state_q, state_d;
  logic        pending_q, pending_d;
  logic [5:0]  min_s_q, min_s_d;
  logic [5:0]  sec_s_q, sec_s_d;
  logic [5:0]  min_sh_q, min_sh_d;
  logic [5:0]  sec_sh_q, sec_sh_d;
  logic [7:0]  min_bcd_q, min_bcd_d;
  logic [7:0]  sec_bcd_q, sec_bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic        busy_q, busy_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;

  logic [5:0]  min_c;
  logic [5:0]  sec_c;
  logic        start;
  logic [3:0]  dig_sel;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_on;
  logic        lead_blank;

  assign min_c = clamp59(min_bin);
  assign sec_c = clamp59(sec_bin);
  // Compare clamped values so an out-of-range input settles.
  assign start = (state_q == IDLE) &&
                 (pending_q ||
                  (min_c != min_s_q) ||
                  (sec_c != sec_s_q));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    min_s_d   = min_s_q;
    sec_s_d   = sec_s_q;
    min_sh_d  = min_sh_q;
    sec_sh_d  = sec_sh_q;
    min_bcd_d = min_bcd_q;
    sec_bcd_d = sec_bcd_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          min_s_d   = min_c;
          sec_s_d   = sec_c;
          min_sh_d  = min_c;
          sec_sh_d  = sec_c;
          min_bcd_d = 8'h00;
          sec_bcd_d = 8'h00;
          cnt_d     = 3'd0;
          pending_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        min_bcd_d = bcd_step(min_bcd_q, min_sh_q[5]);
        sec_bcd_d = bcd_step(sec_bcd_q, sec_sh_q[5]);
        min_sh_d  = {min_sh_q[4:0], 1'b0};
        sec_sh_d  = {sec_sh_q[4:0], 1'b0};
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == SHIFT_CNT - 3'd1) state_d = COMMIT;
      end
      COMMIT: begin
        digits_d = {min_bcd_q, sec_bcd_q};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = start || (state_q != IDLE);
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_TC) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  always_comb begin
    dig_sel = digits_q[3:0];
    case (idx_q)
      2'd0:    dig_sel = digits_q[3:0];
      2'd1:    dig_sel = digits_q[7:4];
      2'd2:    dig_sel = digits_q[11:8];
      default: dig_sel = digits_q[15:12];
    endcase
  end

  seg7_decode u_dec (
    .digit (dig_sel),
    .seg   (dec_seg)
  );

  assign lead_blank = blank_lead &&
                      (idx_q == 2'd3) &&
                      (digits_q[15:12] == 4'd0);

  always_comb begin
    seg_on = lead_blank ? SEG_BLANK : dec_seg;
    seg_d  = COMMON_ANODE ? ~seg_on : seg_on;
    an_d   = COMMON_ANODE ? ~(4'b0001 << idx_q)
                          : (4'b0001 << idx_q);
    dp_d   = COMMON_ANODE ? (idx_q != 2'd2)
                          : (idx_q == 2'd2);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      pending_q <= 1'b1;
      min_s_q   <= '0;
      sec_s_q   <= '0;
      min_sh_q  <= '0;
      sec_sh_q  <= '0;
      min_bcd_q <= '0;
      sec_bcd_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      busy_q    <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
      an_q      <= AN_OFF;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      min_s_q   <= min_s_d;
      sec_s_q   <= sec_s_d;
      min_sh_q  <= min_sh_d;
      sec_sh_q  <= sec_sh_d;
      min_bcd_q <= min_bcd_d;
      sec_bcd_q <= sec_bcd_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      busy_q    <= busy_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display with a small
// arithmetic reference model of the expected display.
module tb_stopwatch_display;

  localparam int SD = 4;

  localparam logic [6:0] SEGL [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [5:0] min_bin = '0;
  logic [5:0] sec_bin = '0;
  logic       blank_lead = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int edges;

  always #5 clk = ~clk;

  always @(posedge clk or negedge clr) begin
    if (!clr) edges <= 0;
    else      edges <= edges + 1;
  end

  stopwatch_display #(
    .SCAN_DIV     (SD),
    .COMMON_ANODE (1'b1)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .min_bin    (min_bin),
    .sec_bin    (sec_bin),
    .blank_lead (blank_lead),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (busy && n < 60) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
  endtask

  // Two full refresh periods; expected digit derived from time since reset.
  task automatic check_display(
    input string name,
    input int    m,
    input int    s,
    input bit    bl
  );
    int         mc, sc, idx;
    logic [6:0] exp_seg [4];
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    mc = (m > 59) ? 59 : m;
    sc = (s > 59) ? 59 : s;
    exp_seg[0] = SEGL[sc % 10];
    exp_seg[1] = SEGL[sc / 10];
    exp_seg[2] = SEGL[mc % 10];
    exp_seg[3] = (bl && (mc / 10) == 0) ? 7'h7F
                                        : SEGL[mc / 10];
    for (int i = 0; i < 8 * SD; i++) begin
      tick();
      idx  = ((edges - 1) / SD) % 4;
      ean  = ~(4'b0001 << idx);
      eseg = exp_seg[idx];
      edp  = (idx == 2) ? 1'b0 : 1'b1;
      vectors++;
      if ({an, seg, dp} !== {ean, eseg, edp}) begin
        miscompares++;
        $display("FAIL %s: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 name, an, seg, dp, ean, eseg, edp);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    min_bin = 6'd0;
    sec_bin = 6'd0;
    blank_lead = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({seg, an, dp, busy} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: seg=%h an=%h dp=%b busy=%b required 7f f 1 0",
               seg, an, dp, busy);
    end
    @(negedge clk);
    clr = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      vectors++;
      if (busy !== (k <= 8)) begin
        miscompares++;
        $display("FAIL busy_edge%0d: busy=%b required %b", k, busy, k <= 8);
      end
      if (k == 1) begin
        vectors++;
        if ({an, seg, dp} !== {4'hE, 7'h40, 1'b1}) begin
          miscompares++;
          $display("FAIL first_scan: an=%h seg=%h dp=%b required e 40 1",
                   an, seg, dp);
        end
      end
    end
    check_display("zero", 0, 0, 1'b0);
  endtask

  task automatic apply(input int m, input int s, input bit bl);
    min_bin = 6'(m);
    sec_bin = 6'(s);
    blank_lead = bl;
    wait_idle();
  endtask

  task automatic test_convert();
    apply(12, 59, 1'b0);
    check_display("12:59", 12, 59, 1'b0);
  endtask

  task automatic test_clamp();
    apply(63, 60, 1'b0);
    check_display("clamp", 63, 60, 1'b0);
  endtask

  task automatic test_blank();
    apply(5, 37, 1'b1);
    check_display("blank_05", 5, 37, 1'b1);
    apply(45, 8, 1'b1);
    check_display("noblank_45", 45, 8, 1'b1);
  endtask

  task automatic test_back_to_back();
    int run;
    bit seen_low;
    run = 0;
    seen_low = 1'b0;
    min_bin = 6'd3;
    sec_bin = 6'd10;
    blank_lead = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) sec_bin = 6'd11;
      if (!seen_low && busy) run++;
      else seen_low = 1'b1;
    end
    vectors++;
    if (run != 16) begin
      miscompares++;
      $display("FAIL back_to_back_busy: run=%0d required 16", run);
    end
    check_display("b2b_03:11", 3, 11, 1'b0);
  endtask

  task automatic test_clr_mid();
    min_bin = 6'd7;
    sec_bin = 6'd42;
    repeat (3) tick();
    clr = 1'b0;
    #1;
    vectors++;
    if ({seg, an, dp, busy} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL clr_mid: seg=%h an=%h dp=%b busy=%b required 7f f 1 0",
               seg, an, dp, busy);
    end
    @(negedge clk);
    clr = 1'b1;
    wait_idle();
    check_display("after_clr", 7, 42, 1'b0);
  endtask

  task automatic test_random();
    int m, s;
    bit bl;
    for (int i = 0; i < 20; i++) begin
      m  = $urandom_range(0, 63);
      s  = $urandom_range(0, 63);
      bl = 1'($urandom_range(0, 1));
      apply(m, s, bl);
      check_display("random", m, s, bl);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_clamp();
    test_blank();
    test_back_to_back();
    test_clr_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Stopwatch display stage. It takes the binary minute and second counts produced by the mod-60 up/down counters and converts each to two BCD digits with a sequential shift-add-3 converter. It then time-multiplexes the four digits onto a common-anode 4-digit 7-segment display.

## Interface
- SCAN_DIV, 50000: clk cycles each digit stays lit; legal range ≥2.
- COMMON_ANODE, 1: 1 means seg/dp/an are active-low; 0 means active-high.

- clk  in  1  system clock. Reset clr is asynchronous and active-low; clock is clk.
- clr  in  1  asynchronous reset, active-low.
- min_bin  in  6  minutes, binary, 0–59.
- sec_bin  in  6  seconds, binary, 0–59.
- blank_lead  in  1  1 blanks the minutes-tens digit when it is 0.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0] is segment a.
- dp  out  1  decimal point; lit only on digit 2, as the min/sec separator.
- an  out  4  digit enables; an[3]=min tens, an[2]=min ones, an[1]=sec tens, an[0]=sec ones.
- busy  out  1  high while a conversion is in SHIFT or COMMIT.

## Operation
- Input clamp: any value >59 is treated as 59 when it is snapshotted.
- Snapshot registers min_s and sec_s hold the last converted inputs. On reset, a pending flag forces one conversion.
- Converter FSM states:
  - IDLE: if the pending flag is set, or (min_bin, sec_bin) differs from the snapshot, capture the clamped inputs into the snapshot and the shift registers, clear both 8-bit BCD accumulators, set shift count to 0, clear pending, go to SHIFT.
  - SHIFT: each cycle, for both lanes in parallel, add 3 to every BCD nibble ≥5, then shift the binary MSB into the BCD accumulator. After the 6th shift, go to COMMIT.
  - COMMIT: copy the accumulators to digit registers d3..d0, go to IDLE.
- Input changes during SHIFT or COMMIT are ignored. The IDLE compare catches them after COMMIT, so the final displayed value always matches the final stable input.
- Scan logic:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count, digit index (2-bit) increments and wraps from 3 to 0.
- Output register: each clk, an/seg/dp are loaded from the current index:
  - an gets a one-hot enable.
  - seg gets the decode of the selected digit register.
  - dp is on when index==2.
- Blanking: if blank_lead=1 and d3==0, digit 3 shows all segments off, but an[3] is still asserted.
- Polarity: with COMMON_ANODE=1, "on" is 0 for seg, dp and an.

## Timing
- Reset values (COMMON_ANODE=1):
  - seg=7'h7F, dp=1, an=4'hF, busy=0.
  - d3..d0=0, index=0, prescaler=0, FSM=IDLE, pending=1.
- After clr deasserts:
  - First IDLE edge starts the conversion.
  - Digits are valid 8 edges later.
  - an/seg first drive on the first edge after clr release, showing index 0 (an=4'hE).
- Conversion latency: the edge that accepts the new input in IDLE is edge 1; edges 2–7 are SHIFT; edge 8 is COMMIT and updates the digit registers.
- busy is high from edge 1 through edge 8, then drops on the following edge.
- seg reflects a new digit on the first edge after COMMIT at which that digit is selected.
- Scan period: 4×SCAN_DIV cycles per full refresh. The index advances on the edge where the prescaler goes from SCAN_DIV-1 to 0.
- Scanning is independent of conversion; it never stalls.
- clr asserted mid-conversion: everything returns to reset values immediately and the partial result is discarded.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, SHIFT, COMMIT);
  - the active-high segment constants for 0–9 and SEG_BLANK;
  - the clamp limit 59;
  - the shift count 6.
- Sub-module seg7_decode: combinational 4-bit to 7-segment lookup, active-high. The polarity inversion happens in the parent. Codes 10–15 decode to blank.

## Test plan
- Reset, then SCAN_DIV=4, min=0, sec=0, blank_lead=0 -> busy high for 8 edges; then an cycles E,D,B,7 every 4 clk; seg=7'h40 on every digit; dp=0 only while an=B.
- min=12, sec=59 -> after COMMIT, d3..d0=1,2,5,9; seg=7'h79 during an=7, 7'h12 during an=D, 7'h10 during an=E.
- min=63, sec=60 -> clamped; display reads 59:59.
- blank_lead=1, min=5 -> during an=7, seg=7'h7F; digit 2 shows 5 (seg=7'h12).
- sec changes 10→11 at SHIFT cycle 3 -> first conversion commits 10, then a second conversion starts immediately; final d1d0=1,1; busy high for 16 consecutive edges.
- clr pulsed low mid-SHIFT -> outputs immediately seg=7'h7F, an=4'hF, dp=1; a fresh conversion runs after release.
